// File: rtl/io_debounce_pkg.sv
// Shared configuration types and constants for the io_debounce input conditioner.
package io_debounce_pkg;

    localparam int DEFAULT_DEBOUNCE_TICKS = 10000;
    localparam int DEFAULT_TICK_DIV       = 50;

    // Top-level configuration handed down to the per-channel instances.
    typedef struct packed {
        int channels;
        int tick_div;
        int debounce_ticks;
    } io_cfg_t;

    // Bits needed to hold any value in 0..max_val (never less than one bit).
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One input channel: synchroniser, optional inversion, tick-based debounce
// counter, debounced level and single-cycle rise/fall pulses.
module debounce_channel
    import io_debounce_pkg::*;
#(
    parameter io_cfg_t CFG         = '{channels: 12, tick_div: DEFAULT_TICK_DIV,
                                       debounce_ticks: DEFAULT_DEBOUNCE_TICKS},
    parameter int      SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    input  logic tick,
    input  logic invert,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int             CW       = cnt_width(CFG.debounce_ticks);
    localparam logic [CW-1:0]  CNT_LAST = CW'(CFG.debounce_ticks - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_cnt;
    logic                   r_level;
    logic                   r_rise;
    logic                   r_fall;
    logic                   w_sample;

    // Polarity-normalised sample taken from the last synchroniser stage.
    assign w_sample = r_sync[SYNC_STAGES-1] ^ invert;

    // Synchronise the pin, then accept a new value only once it has persisted
    // for the full run of ticks; any agreement with the current level restarts
    // the count, which is what rejects contact bounce.
    // NOTE: every register here uses <= so all of them see pre-edge values;
    // a blocking assignment would let the shift chain collapse in one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync  <= '0;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], raw};
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (w_sample == r_level) begin
                r_cnt <= '0;
            end else if (tick) begin
                if (r_cnt == CNT_LAST) begin
                    r_level <= w_sample;
                    r_cnt   <= '0;
                    r_rise  <= w_sample;
                    r_fall  <= ~w_sample;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

    assign level = r_level;
    assign rise  = r_rise;
    assign fall  = r_fall;

endmodule

// File: rtl/io_debounce.sv
// Board pin conditioner: shared debounce prescaler, one debounce_channel per
// pin, and a sticky event flag summarising every edge until acknowledged.
module io_debounce
    import io_debounce_pkg::*;
#(
    parameter int                  CHANNELS       = 12,
    parameter int                  SYNC_STAGES    = 2,
    parameter int                  TICK_DIV       = DEFAULT_TICK_DIV,
    parameter int                  DEBOUNCE_TICKS = DEFAULT_DEBOUNCE_TICKS,
    parameter logic [CHANNELS-1:0] INVERT         = 12'b0000_0000_0011
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] raw,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic                evt,
    input  logic                evt_ack
);

    localparam io_cfg_t       CFG       = '{channels: CHANNELS, tick_div: TICK_DIV,
                                            debounce_ticks: DEBOUNCE_TICKS};
    localparam int            PW        = cnt_width(TICK_DIV - 1);
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] r_presc;
    logic          r_evt;
    logic          w_tick;

    assign w_tick = (r_presc == TICK_LAST);

    // Free-running prescaler: wraps after TICK_DIV cycles, tick on the last count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    for (genvar g = 0; g < CFG.channels; g++) begin : g_ch
        debounce_channel #(
            .CFG         (CFG),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .raw    (raw[g]),
            .tick   (w_tick),
            .invert (INVERT[g]),
            .level  (level[g]),
            .rise   (rise[g]),
            .fall   (fall[g])
        );
    end

    // Sticky event flag; a new edge outranks a simultaneous acknowledge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_evt <= 1'b0;
        end else if (|(rise | fall)) begin
            r_evt <= 1'b1;
        end else if (evt_ack) begin
            r_evt <= 1'b0;
        end
    end

    assign evt = r_evt;

endmodule

// File: tb/tb_io_debounce.sv
// Self-checking bench for io_debounce: an edge-counting reference model feeds
// a scoreboard queue that a separate monitor drains every cycle, plus directed
// latency / handshake checks and a randomized soak.
module tb_io_debounce;

    localparam int            CH   = 4;
    localparam int            SYNC = 2;
    localparam int            TD   = 4;
    localparam int            DT   = 3;
    localparam logic [CH-1:0] INV  = 4'b0001;
    localparam int            LAT_MIN = SYNC + (DT - 1) * TD + 1;
    localparam int            LAT_MAX = SYNC + DT * TD;

    typedef struct packed {
        logic [CH-1:0] level;
        logic [CH-1:0] rise;
        logic [CH-1:0] fall;
        logic          evt;
    } obs_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [CH-1:0] raw;
    logic [CH-1:0] level;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
    logic          evt;
    logic          evt_ack;

    int n_tests = 0;
    int n_fail  = 0;

    io_debounce #(
        .CHANNELS       (CH),
        .SYNC_STAGES    (SYNC),
        .TICK_DIV       (TD),
        .DEBOUNCE_TICKS (DT),
        .INVERT         (INV)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .raw     (raw),
        .level   (level),
        .rise    (rise),
        .fall    (fall),
        .evt     (evt),
        .evt_ack (evt_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Each channel tracks when its normalised sample started disagreeing with
    // the accepted level; the level flips on the tick where the number of
    // ticks seen since then reaches DT. Ticks fall on every edge index e
    // (counted from reset release) with e % TD == TD-1.
    logic [CH-1:0] m_pipe[$];
    logic [CH-1:0] m_level, m_rise, m_fall;
    logic          m_evt;
    int            m_run[CH];
    int            m_e;
    obs_t          sb[$];

    function automatic int ticks_between(input int s, input int e);
        return (e + 1) / TD - s / TD;
    endfunction

    task automatic model_reset();
        m_pipe.delete();
        for (int i = 0; i < SYNC; i++) m_pipe.push_back('0);
        m_level = '0; m_rise = '0; m_fall = '0; m_evt = 1'b0;
        for (int i = 0; i < CH; i++) m_run[i] = -1;
        m_e = 0;
    endtask

    initial model_reset();

    always @(posedge clk) begin
        logic [CH-1:0] smp, nr, nf, had_edge;
        if (rst) begin
            model_reset();
        end else begin
            smp      = m_pipe[0] ^ INV;
            had_edge = m_rise | m_fall;
            nr = '0; nf = '0;
            for (int i = 0; i < CH; i++) begin
                if (smp[i] == m_level[i]) begin
                    m_run[i] = -1;
                end else begin
                    if (m_run[i] < 0) m_run[i] = m_e;
                    if ((m_e % TD) == TD - 1 && ticks_between(m_run[i], m_e) == DT) begin
                        m_level[i] = smp[i];
                        nr[i] = smp[i];
                        nf[i] = ~smp[i];
                        m_run[i] = -1;
                    end
                end
            end
            if (|had_edge)    m_evt = 1'b1;
            else if (evt_ack) m_evt = 1'b0;
            m_rise = nr;
            m_fall = nf;
            m_pipe.push_back(raw);
            void'(m_pipe.pop_front());
            m_e++;
        end
        sb.push_back('{level: m_level, rise: m_rise, fall: m_fall, evt: m_evt});
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        obs_t x;
        obs_t a;
        if (sb.size() > 0) begin
            x = sb.pop_front();
            a = '{level: level, rise: rise, fall: fall, evt: evt};
            check("scoreboard", 32'(a), 32'(x));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_level(input int ch, input logic val, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (level[ch] !== val && n < 40);
    endtask

    task automatic check_latency(input string name, input int n);
        check(name, 32'(n >= LAT_MIN && n <= LAT_MAX), 32'd1);
    endtask

    initial begin
        int n;
        int pulses;
        logic [CH-1:0] msk;

        // 1. Reset behaviour
        rst = 1'b1; raw = 4'b0001; evt_ack = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_level", 32'(level), 32'd0);
        check("rst_evt", 32'(evt), 32'd0);
        rst = 1'b0;
        pulses = 0;
        repeat (30) begin
            @(negedge clk);
            if (level != 0 || rise != 0 || fall != 0 || evt) pulses++;
        end
        check("t1_quiet", 32'(pulses), 32'd0);

        // 2. Clean press on ch1
        raw[1] = 1'b1;
        wait_level(1, 1'b1, n);
        check_latency("t2_latency", n);
        check("t2_rise", 32'(rise), 32'b0010);
        @(negedge clk);
        check("t2_rise_gone", 32'(rise), 32'd0);
        check("t2_evt", 32'(evt), 32'd1);
        evt_ack = 1'b1;
        @(negedge clk);
        evt_ack = 1'b0;

        // 3. Bounce rejection on ch2
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            raw[2] = ~raw[2];
            repeat (5) begin
                @(negedge clk);
                if (rise[2] || fall[2]) pulses++;
            end
        end
        check("t3_no_pulse", 32'(pulses), 32'd0);
        raw[2] = 1'b1;
        wait_level(2, 1'b1, n);
        check_latency("t3_latency", n);
        check("t3_rise", 32'(rise[2]), 32'd1);

        // 4. Active-low key on ch0
        raw[0] = 1'b0;
        wait_level(0, 1'b1, n);
        check_latency("t4_press", n);
        check("t4_rise", 32'(rise[0]), 32'd1);
        repeat (3) @(negedge clk);
        raw[0] = 1'b1;
        wait_level(0, 1'b0, n);
        check_latency("t4_release", n);
        check("t4_fall", 32'(fall[0]), 32'd1);

        // 5. evt handshake: ack coincident with fall[3]
        raw[3] = 1'b1;
        wait_level(3, 1'b1, n);
        repeat (3) @(negedge clk);
        check("t5_evt_set", 32'(evt), 32'd1);
        raw[3] = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fall[3] && n < 40);
        check("t5_fall_seen", 32'(fall[3]), 32'd1);
        evt_ack = 1'b1;
        @(negedge clk);
        evt_ack = 1'b0;
        check("t5_set_wins", 32'(evt), 32'd1);
        repeat (2) @(negedge clk);
        evt_ack = 1'b1;
        @(negedge clk);
        evt_ack = 1'b0;
        check("t5_ack_clears", 32'(evt), 32'd0);

        // 6. Reset mid-debounce on ch1
        raw[1] = 1'b0;
        wait_level(1, 1'b0, n);
        repeat (2) @(negedge clk);
        raw[1] = 1'b1;
        repeat (8) @(negedge clk);
        check("t6_not_yet", 32'(level[1]), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_level_clr", 32'(level), 32'd0);
        check("t6_no_pulse", 32'(rise | fall), 32'd0);
        wait_level(1, 1'b1, n);
        check_latency("t6_relatency", n);

        // Randomized soak against the reference model
        repeat (3000) begin
            @(negedge clk);
            if ($urandom_range(0, 11) == 0) begin
                msk = CH'($urandom_range(1, (1 << CH) - 1));
                raw = raw ^ msk;
            end
            evt_ack = ($urandom_range(0, 7) == 0);
            rst     = ($urandom_range(0, 699) == 0);
        end
        rst = 1'b0; evt_ack = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
